// File: rtl/snake_mover.sv
// Snake body mover: reads each segment from external storage, steps it one cell
// along its own direction, and writes it back with the direction of the segment ahead.
module snake_mover (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] head_dir,
    input  logic [7:0] length,
    input  logic [7:0] rd_pos,
    input  logic [7:0] rd_dir,
    output logic [7:0] addr,
    output logic [3:0] mode,
    output logic       load_out,
    output logic       wren,
    output logic [7:0] wr_pos,
    output logic [7:0] wr_dir,
    output logic       busy,
    output logic       done,
    output logic       collide
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR      = 3'd3;
    localparam logic [2:0] FIN     = 3'd4;

    localparam logic [3:0] MODE_IDLE  = 4'b0000;
    localparam logic [3:0] MODE_READ  = 4'b0001;
    localparam logic [3:0] MODE_WRITE = 4'b0011;

    logic [2:0] state;
    logic [7:0] idx;
    logic [7:0] len_q;
    logic [1:0] hdir_q;
    logic [1:0] prev_dir;
    logic [7:0] head_pos;
    logic [7:0] stepped;
    logic       last_seg;
    logic       unused_dir_bits;

    // Each axis wraps independently on the 16x16 board.
    function automatic logic [7:0] step_cell(input logic [7:0] pos, input logic [1:0] dir);
        logic [3:0] x;
        logic [3:0] y;
        x = pos[3:0];
        y = pos[7:4];
        case (dir)
            2'b00:   x = x + 4'd1;
            2'b01:   x = x - 4'd1;
            2'b10:   y = y + 4'd1;
            default: y = y - 4'd1;
        endcase
        return {y, x};
    endfunction

    assign stepped         = step_cell(rd_pos, rd_dir[1:0]);
    assign last_seg        = (idx == (len_q - 8'd1));
    assign unused_dir_bits = ^rd_dir[7:2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= 8'd0;
            len_q    <= 8'd0;
            hdir_q   <= 2'b00;
            prev_dir <= 2'b00;
            head_pos <= 8'd0;
            wr_pos   <= 8'd0;
            wr_dir   <= 8'd0;
            collide  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        collide <= 1'b0;
                        idx     <= 8'd0;
                        if (length != 8'd0) begin
                            len_q  <= length;
                            hdir_q <= head_dir;
                            state  <= RD_REQ;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    // Storage data is valid now; prev_dir still holds segment idx-1's old direction.
                    wr_pos   <= stepped;
                    wr_dir   <= {6'b0, (idx == 8'd0) ? hdir_q : prev_dir};
                    prev_dir <= rd_dir[1:0];
                    if (idx == 8'd0) begin
                        head_pos <= stepped;
                    end else if (stepped == head_pos) begin
                        collide <= 1'b1;
                    end
                    state <= WR;
                end
                WR: begin
                    if (last_seg) begin
                        state <= FIN;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= RD_REQ;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        addr     = 8'd0;
        mode     = MODE_IDLE;
        load_out = 1'b0;
        wren     = 1'b0;
        case (state)
            RD_REQ: begin
                addr     = idx;
                mode     = MODE_READ;
                load_out = 1'b1;
            end
            WR: begin
                addr = idx;
                mode = MODE_WRITE;
                wren = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state == RD_REQ) || (state == RD_WAIT) || (state == WR);
    assign done = (state == FIN);

endmodule

// File: tb/tb_snake_mover.sv
// Bench for snake_mover: a storage model plus a board-level reference of how the snake moves.
module tb_snake_mover;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] head_dir;
    logic [7:0] length;
    logic [7:0] rd_pos;
    logic [7:0] rd_dir;
    logic [7:0] addr;
    logic [3:0] mode;
    logic       load_out;
    logic       wren;
    logic [7:0] wr_pos;
    logic [7:0] wr_dir;
    logic       busy;
    logic       done;
    logic       collide;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem_pos [256];
    logic [1:0] mem_dir [256];
    bit         pend_rd;
    logic [7:0] pend_addr;

    snake_mover dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .head_dir (head_dir),
        .length   (length),
        .rd_pos   (rd_pos),
        .rd_dir   (rd_dir),
        .addr     (addr),
        .mode     (mode),
        .load_out (load_out),
        .wren     (wren),
        .wr_pos   (wr_pos),
        .wr_dir   (wr_dir),
        .busy     (busy),
        .done     (done),
        .collide  (collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] step_ref(input logic [7:0] p, input logic [1:0] d);
        int x;
        int y;
        x = int'(p) % 16;
        y = int'(p) / 16;
        case (d)
            2'd0:    x = (x + 1) % 16;
            2'd1:    x = (x + 15) % 16;
            2'd2:    y = (y + 1) % 16;
            default: y = (y + 15) % 16;
        endcase
        return 8'(y * 16 + x);
    endfunction

    function automatic logic [16:0] mk(input bit b, input bit dn, input bit l, input bit w,
                                       input bit c, input logic [3:0] m, input logic [7:0] a);
        return {b, dn, l, w, c, m, a};
    endfunction

    function automatic logic [16:0] ctl_now();
        return {busy, done, load_out, wren, collide, mode, addr};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Storage: reads return one cycle after load_out, writes land when wren is seen.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pend_rd) begin
            rd_pos  = mem_pos[pend_addr];
            rd_dir  = {6'($urandom), mem_dir[pend_addr]};
            pend_rd = 1'b0;
        end
        if (load_out) begin
            pend_rd   = 1'b1;
            pend_addr = addr;
        end
        if (wren) begin
            mem_pos[addr] = wr_pos;
            mem_dir[addr] = wr_dir[1:0];
        end
    endtask

    task automatic run_move(input int len, input logic [1:0] hd, input bit noise);
        logic [7:0]  np [256];
        logic [1:0]  nd [256];
        int          total;
        int          seg;
        int          ph;
        bit          cexp;
        logic [16:0] e;
        for (int i = 0; i < len; i++) begin
            np[i] = step_ref(mem_pos[i], mem_dir[i]);
            nd[i] = (i == 0) ? hd : mem_dir[i-1];
        end
        total    = (len == 0) ? 1 : 3 * len + 1;
        length   = 8'(len);
        head_dir = hd;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= total + 1; k++) begin
            cexp = 1'b0;
            for (int j = 1; j < len; j++)
                if (3 * j + 3 <= k && np[j] == np[0]) cexp = 1'b1;
            seg = (k - 1) / 3;
            ph  = (k - 1) % 3;
            if (k < total) begin
                case (ph)
                    0:       e = mk(1, 0, 1, 0, cexp, 4'b0001, 8'(seg));
                    1:       e = mk(1, 0, 0, 0, cexp, 4'b0000, 8'd0);
                    default: e = mk(1, 0, 0, 1, cexp, 4'b0011, 8'(seg));
                endcase
            end else if (k == total) begin
                e = mk(0, 1, 0, 0, cexp, 4'b0000, 8'd0);
            end else begin
                e = mk(0, 0, 0, 0, cexp, 4'b0000, 8'd0);
            end
            check("ctl", 32'(ctl_now()), 32'(e));
            if (k < total && ph == 2) begin
                check("wr_pos", 32'(wr_pos), 32'(np[seg]));
                check("wr_dir", 32'(wr_dir), {30'd0, nd[seg]});
            end
            if (noise) begin
                head_dir = 2'($urandom);
                length   = 8'($urandom);
                start    = (k == 2 && len > 0);
            end
            if (k <= total) tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int len;
        start    = 1'b0;
        head_dir = 2'b00;
        length   = 8'd0;
        rd_pos   = 8'd0;
        rd_dir   = 8'd0;
        pend_rd  = 1'b0;
        pend_addr = 8'd0;
        for (int i = 0; i < 256; i++) begin
            mem_pos[i] = 8'($urandom);
            mem_dir[i] = 2'($urandom);
        end

        reset = 1'b0;
        tick();
        tick();
        check("reset_ctl", 32'(ctl_now()), 32'd0);
        check("reset_wr_pos", 32'(wr_pos), 32'd0);
        check("reset_wr_dir", 32'(wr_dir), 32'd0);
        reset = 1'b1;
        tick();
        check("idle_ctl", 32'(ctl_now()), 32'd0);

        run_move(0, 2'b01, 1'b0);

        mem_pos[0] = 8'h35; mem_dir[0] = 2'b00;
        run_move(1, 2'b10, 1'b0);
        check("single_pos", 32'(mem_pos[0]), 32'h36);
        check("single_dir", 32'(mem_dir[0]), 32'h2);
        check("single_collide", 32'(collide), 32'd0);

        mem_pos[0] = 8'h0F; mem_dir[0] = 2'b00;
        run_move(1, 2'b00, 1'b0);
        check("wrap_x", 32'(mem_pos[0]), 32'h00);
        mem_pos[0] = 8'h00; mem_dir[0] = 2'b11;
        run_move(1, 2'b00, 1'b0);
        check("wrap_y", 32'(mem_pos[0]), 32'hF0);

        mem_pos[0] = 8'h44; mem_dir[0] = 2'b00;
        mem_pos[1] = 8'h43; mem_dir[1] = 2'b10;
        mem_pos[2] = 8'h33; mem_dir[2] = 2'b01;
        run_move(3, 2'b11, 1'b0);
        check("prop_dir0", 32'(mem_dir[0]), 32'h3);
        check("prop_dir1", 32'(mem_dir[1]), 32'h0);
        check("prop_dir2", 32'(mem_dir[2]), 32'h2);

        mem_pos[0] = 8'h11; mem_dir[0] = 2'b00;
        mem_pos[1] = 8'h13; mem_dir[1] = 2'b01;
        run_move(2, 2'b00, 1'b0);
        check("collide_held", 32'(collide), 32'd1);
        tick();
        check("collide_still", 32'(collide), 32'd1);
        run_move(4, 2'b01, 1'b1);

        // Abort during the second RD_WAIT of a three-segment move.
        length = 8'd3; head_dir = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 5; k++) tick();
        check("abort_pre", 32'(ctl_now()), 32'(mk(1, 0, 0, 0, 0, 4'b0000, 8'd0)));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_ctl", 32'(ctl_now()), 32'd0);
        check("abort_wr_pos", 32'(wr_pos), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("abort_quiet", 32'(ctl_now()), 32'd0);
        end

        length = 8'd5; start = 1'b1; reset = 1'b0;
        tick();
        reset = 1'b1; start = 1'b0;
        check("rst_prio", 32'(ctl_now()), 32'd0);
        tick();
        check("rst_prio_next", 32'(ctl_now()), 32'd0);

        for (int n = 0; n < 12; n++) begin
            len = int'($urandom_range(1, 20));
            run_move(len, 2'($urandom), 1'b1);
        end
        for (int i = 0; i < 256; i++) begin
            mem_pos[i] = 8'($urandom);
            mem_dir[i] = 2'($urandom);
        end
        run_move(255, 2'($urandom), 1'b1);
        check("len255_top_untouched", 32'(addr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/snake_mover.md
SNAKE_MOVER -- requirements
Module: snake_mover

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: clk in 1 (rising edge), then reset in 1 (active-low, synchronous).
REQ-002 The module SHALL have the following ports:
- start  in  1  move request; single-cycle pulse, sampled only in IDLE.
- head_dir  in  2  new head direction: 00 right, 01 left, 10 down, 11 up.
- length  in  8  segment count, sampled on accepted start.
- rd_pos  in  8  storage read position {y[7:4], x[3:0]}.
- rd_dir  in  8  storage read direction; only [1:0] used.
- addr  out  8  storage address; segment 0 is the head.
- mode  out  4  storage mode: 4'b0000 idle, 4'b0001 read, 4'b0011 write.
- load_out  out  1  storage read strobe.
- wren  out  1  storage write strobe.
- wr_pos  out  8  position to write.
- wr_dir  out  8  direction to write; [7:2] always 0.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- collide  out  1  head overlapped a body segment on the last move; held until the next accepted start.

Function
REQ-003 The FSM SHALL have states IDLE, RD_REQ, RD_WAIT, WR and FIN.
REQ-004 In IDLE, start=1 with length!=0 SHALL do all of the following: latch length and head_dir; set seg index i=0; clear collide; set busy; go to RD_REQ.
REQ-005 In IDLE, start=1 with length=0 SHALL go to FIN with no storage access.
REQ-006 RD_REQ SHALL drive addr=i, mode=4'b0001 and load_out=1 for exactly one cycle, then go to RD_WAIT.
REQ-007 Storage read latency is one cycle: rd_pos/rd_dir SHALL be captured on the RD_WAIT clock edge, then the FSM goes to WR.
REQ-008 WR SHALL drive addr=i, mode=4'b0011 and wren=1 for exactly one cycle.
REQ-009 In WR, wr_pos SHALL equal the captured pos stepped one cell along the captured dir[1:0].
REQ-010 In WR, wr_dir SHALL be {6'b0, latched head_dir} for i=0, and {6'b0, old dir of segment i-1} for i>0 (propagated through a prev_dir register).
REQ-011 Step arithmetic SHALL be 4-bit modulo per axis, no carry between axes:
- right x+1; left x-1; down y+1; up y-1.
- Boundaries wrap: x=15 right -> 0; x=0 left -> 15; same for y.
REQ-012 The new head pos SHALL be held in a register; for i>0, if wr_pos equals it, collide SHALL set in that WR cycle.
REQ-013 After WR: if i==length-1, go to FIN; else i=i+1 and go to RD_REQ. Per-segment cost SHALL be exactly 3 cycles.
REQ-014 FIN SHALL pulse done=1 for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-015 start asserted while busy SHALL be ignored.
REQ-016 head_dir and length changes while busy SHALL have no effect.
REQ-017 Outside RD_REQ/WR, mode SHALL be 4'b0000, load_out=0 and wren=0.
REQ-018 load_out and wren SHALL never be asserted in the same cycle.
REQ-019 length=255 SHALL process addresses 0..254; addr SHALL never exceed length-1.
REQ-020 Total latency from accepted start to the done pulse SHALL be 3*length+1 cycles; for length=0 it SHALL be 1 cycle.

Reset
REQ-021 On reset=0 at a clock edge, the FSM SHALL enter IDLE and all outputs SHALL clear to 0 (addr=0, mode=4'b0000, wr_pos=0, wr_dir=0, busy=0, done=0, collide=0); internal index, prev_dir and head-pos registers SHALL also clear.
REQ-022 Reset asserted mid-operation SHALL abort the move in that cycle: no further wren/load_out pulses and no done pulse.
REQ-023 Reset SHALL take priority over start in the same cycle.

Verification
REQ-024 Single segment: length=1, seg0 pos=8'h35, dir=00, head_dir=10 -> one write at addr 0 with pos=8'h36, dir=8'h02; done 4 cycles after start; collide=0.
REQ-025 Wrap: seg0 pos=8'h0F, dir=00 -> write pos=8'h00. Seg0 pos=8'h00, dir=11 -> write pos=8'hF0.
REQ-026 Direction propagation: length=3, dirs {00,10,01}, head_dir=11 -> written dirs {03,00,02}; addr sequence 0,0,1,1,2,2; done at cycle 10 after start.
REQ-027 Collision: length=2, seg0 pos=8'h11 dir=00, seg1 pos=8'h13 dir=01 (both new pos 8'h12) -> collide=1 in seg1 WR, held after done; cleared on next start.
REQ-028 Edge handling: length=0 -> done 1 cycle after start with no strobes. start re-pulsed while busy -> ignored. reset=0 during the second RD_WAIT -> busy=0 next cycle, no further wren, no done.
